riscv_id_pipe: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/riscv_regfile.sv | 43 ++++
 rtl/riscv_id_pipe.sv | 175 +++++++++++++++++
 tb/tb_riscv_id_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, mcause codes
// and the fixed ECALL/EBREAK encodings.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        CAUSE_NONE    = 4'd0,
        CAUSE_ILLEGAL = 4'd2,
        CAUSE_BREAK   = 4'd3,
        CAUSE_ECALL_M = 4'd11
    } cause_e;

endpackage

// File: rtl/riscv_regfile.sv
// 2R1W register file, x0 hardwired to zero, write-through bypass.
// Ports: clk/rst_n, write port we/wa/wd, read ports ra1/rd1, ra2/rd2.
module riscv_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int REGA  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [REGA-1:0] wa,
    input  logic [XLEN-1:0] wd,
    input  logic [REGA-1:0] ra1,
    input  logic [REGA-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    // Indices beyond NREGS are dropped on write; reads of them alias
    // but the decoder flags such instructions illegal anyway.
    assign wr_ok = we && (wa != '0) && (int'(wa) < NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wa[IW-1:0]] <= wd;
        end
    end

    assign rd1 = (ra1 == '0)           ? '0 :
                 (we && (wa == ra1))   ? wd :
                 regs[ra1[IW-1:0]];
    assign rd2 = (ra2 == '0)           ? '0 :
                 (we && (wa == ra2))   ? wd :
                 regs[ra2[IW-1:0]];

endmodule

// File: rtl/riscv_id_pipe.sv
// RISC-V decode stage: regfile read, immediate/operand select, exception cause.
// Ports: fetch in_valid/in_ready/instruction/pc, flush, execute out_* bundle, wb_* write-back.
module riscv_id_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int REGA  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [REGA-1:0] rd,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] sd,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic [6:0]      opcode,
    output logic            exception,
    output logic [3:0]      cause,
    input  logic            wb_en,
    input  logic [REGA-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    typedef struct packed {
        logic [REGA-1:0] rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] sd;
        logic [2:0]      funct3;
        logic            funct7_5;
        logic [6:0]      opcode;
        logic            exception;
        logic [3:0]      cause;
    } id_ex_t;

    logic [6:0]      opc;
    logic [REGA-1:0] rs1, rs2, rdi;
    logic [XLEN-1:0] v1, v2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            use_rd, use_rs1, use_rs2, bad_reg;
    cause_e          cause_d;
    id_ex_t          d, q;
    logic            vld;

    assign opc = instruction[6:0];
    assign rs1 = instruction[19:15];
    assign rs2 = instruction[24:20];
    assign rdi = instruction[11:7];

    riscv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .REGA(REGA)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (v1),
        .rd2   (v2)
    );

    // Sized casts of signed values sign-extend to XLEN.
    assign imm_i = XLEN'($signed(instruction[31:20]));
    assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_b = XLEN'($signed({instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21], 1'b0}));

    always_comb begin
        d          = '0;
        d.funct3   = instruction[14:12];
        d.funct7_5 = instruction[30];
        d.opcode   = opc;
        use_rd     = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        cause_d    = CAUSE_NONE;
        unique case (1'b1)
            opc == OPC_LUI: begin
                d.a = imm_u; use_rd = 1'b1;
            end
            opc == OPC_AUIPC: begin
                d.a = pc; d.b = imm_u; use_rd = 1'b1;
            end
            opc == OPC_JAL: begin
                d.a = pc; d.b = XLEN'(4); d.imm = imm_j; use_rd = 1'b1;
            end
            opc == OPC_JALR: begin
                d.a = pc; d.b = XLEN'(4); d.imm = imm_i;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            opc == OPC_BRANCH: begin
                d.a = v1; d.b = v2; d.sd = v2; d.imm = imm_b;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opc == OPC_LOAD, opc == OPC_OP_IMM: begin
                d.a = v1; d.b = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            opc == OPC_STORE: begin
                d.a = v1; d.b = imm_s; d.sd = v2;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opc == OPC_OP: begin
                d.a = v1; d.b = v2;
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opc == OPC_MISC_MEM: begin
                d.a = '0;
            end
            opc == OPC_SYSTEM: begin
                if (instruction == INSN_ECALL)       cause_d = CAUSE_ECALL_M;
                else if (instruction == INSN_EBREAK) cause_d = CAUSE_BREAK;
                else                                 cause_d = CAUSE_ILLEGAL;
            end
            default: cause_d = CAUSE_ILLEGAL;
        endcase
        if (use_rd) d.rd = rdi;
        // Reduced register count: any referenced index past NREGS is illegal.
        bad_reg = (use_rd  && (int'(rdi) >= NREGS)) ||
                  (use_rs1 && (int'(rs1) >= NREGS)) ||
                  (use_rs2 && (int'(rs2) >= NREGS));
        if ((instruction[1:0] != 2'b11) || bad_reg) cause_d = CAUSE_ILLEGAL;
        if (cause_d != CAUSE_NONE) begin
            d.a         = '0;
            d.b         = '0;
            d.imm       = '0;
            d.sd        = '0;
            d.rd        = '0;
            d.exception = 1'b1;
        end
        d.cause = cause_d;
    end

    assign in_ready = !vld || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (in_valid && in_ready) begin
            q   <= d;
            vld <= 1'b1;
        end else if (out_ready) begin
            vld <= 1'b0;
        end
    end

    assign out_valid = vld;
    assign rd        = q.rd;
    assign a         = q.a;
    assign b         = q.b;
    assign imm       = q.imm;
    assign sd        = q.sd;
    assign funct3    = q.funct3;
    assign funct7_5  = q.funct7_5;
    assign opcode    = q.opcode;
    assign exception = q.exception;
    assign cause     = q.cause;

endmodule

// File: tb/tb_riscv_id_pipe.sv
// Testbench for riscv_id_pipe: vector table, hand sequences, random vs model.
// Two instances share stimulus: NREGS=32 and NREGS=16.
module tb_riscv_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic        f75;
        logic [6:0]  op;
        logic        exc;
        logic [3:0]  cause;
    } bund_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        bund_t       exp;
    } vec_t;

    logic        ir32, ov32, f75_32, exc32;
    logic [4:0]  rd32;
    logic [31:0] a32, b32, imm32, sd32;
    logic [2:0]  f3_32;
    logic [6:0]  op32;
    logic [3:0]  cause32;
    logic        ir16, ov16, f75_16, exc16;
    logic [4:0]  rd16;
    logic [31:0] a16, b16, imm16, sd16;
    logic [2:0]  f3_16;
    logic [6:0]  op16;
    logic [3:0]  cause16;
    bund_t       g32, g16;

    assign g32 = {rd32, a32, b32, imm32, sd32, f3_32, f75_32, op32, exc32, cause32};
    assign g16 = {rd16, a16, b16, imm16, sd16, f3_16, f75_16, op16, exc16, cause16};

    riscv_id_pipe #(.XLEN(32), .NREGS(32), .REGA(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .rd(rd32), .a(a32), .b(b32),
        .imm(imm32), .sd(sd32), .funct3(f3_32), .funct7_5(f75_32),
        .opcode(op32), .exception(exc32), .cause(cause32),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    riscv_id_pipe #(.XLEN(32), .NREGS(16), .REGA(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(ov16), .out_ready(out_ready), .rd(rd16), .a(a16), .b(b16),
        .imm(imm16), .sd(sd16), .funct3(f3_16), .funct7_5(f75_16),
        .opcode(op16), .exception(exc16), .cause(cause16),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [148:0] got,
                       input logic [148:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic bund_t mk(input logic [4:0] rd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] sd, input logic [2:0] f3,
                                 input logic f75, input logic [6:0] op,
                                 input logic exc, input logic [3:0] cause);
        return {rd, a, b, imm, sd, f3, f75, op, exc, cause};
    endfunction

    // Reference decode, straight from the ISA rules.
    function automatic bund_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                    input logic [31:0] v1, input logic [31:0] v2,
                                    input int nr);
        bund_t       r;
        logic        u1, u2, ud;
        int          c;
        logic [31:0] ii, is, ib, iu, ij;
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = {ins[31:12], 12'h000};
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        r = '0;
        r.f3 = ins[14:12];
        r.f75 = ins[30];
        r.op = ins[6:0];
        u1 = 1'b0; u2 = 1'b0; ud = 1'b0; c = 0;
        case (ins[6:0])
            7'h37: begin r.a = iu; ud = 1; end
            7'h17: begin r.a = pcv; r.b = iu; ud = 1; end
            7'h6f: begin r.a = pcv; r.b = 4; r.imm = ij; ud = 1; end
            7'h67: begin r.a = pcv; r.b = 4; r.imm = ii; ud = 1; u1 = 1; end
            7'h63: begin r.a = v1; r.b = v2; r.sd = v2; r.imm = ib; u1 = 1; u2 = 1; end
            7'h03, 7'h13: begin r.a = v1; r.b = ii; ud = 1; u1 = 1; end
            7'h23: begin r.a = v1; r.b = is; r.sd = v2; u1 = 1; u2 = 1; end
            7'h33: begin r.a = v1; r.b = v2; ud = 1; u1 = 1; u2 = 1; end
            7'h0f: c = 0;
            7'h73: c = (ins == 32'h73) ? 11 : (ins == 32'h00100073) ? 3 : 2;
            default: c = 2;
        endcase
        if (ud) r.rd = ins[11:7];
        if ((ud && int'(ins[11:7]) >= nr) || (u1 && int'(ins[19:15]) >= nr) ||
            (u2 && int'(ins[24:20]) >= nr)) c = 2;
        if (c != 0) begin
            r.a = '0; r.b = '0; r.imm = '0; r.sd = '0; r.rd = '0;
            r.exc = 1'b1;
            r.cause = 4'(c);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_insn();
        logic [31:0] x;
        x = $urandom;
        case ($urandom % 13)
            0: x[6:0] = 7'h37;
            1: x[6:0] = 7'h17;
            2: x[6:0] = 7'h6f;
            3: x[6:0] = 7'h67;
            4: x[6:0] = 7'h63;
            5: x[6:0] = 7'h03;
            6: x[6:0] = 7'h13;
            7: x[6:0] = 7'h23;
            8: x[6:0] = 7'h33;
            9: x[6:0] = 7'h0f;
            10: case ($urandom % 3)
                    0: x = 32'h0000_0073;
                    1: x = 32'h0010_0073;
                    default: x[6:0] = 7'h73;
                endcase
            default: x = x;
        endcase
        return x;
    endfunction

    logic [31:0] mregs [32];
    vec_t        tv [15];
    bund_t       e32, e16;
    logic        exp_v, acc;

    task automatic do_wb(input logic [4:0] r, input logic [31:0] v);
        wb_en = 1'b1; wb_rd = r; wb_data = v;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    initial begin
        tv[0]  = '{32'hFFF00093, 32'h100, mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 7'h13, 0, 0)};
        tv[1]  = '{32'h002081B3, 32'h100, mk(3, 32'h10, 32'h1234, 0, 0, 0, 0, 7'h33, 0, 0)};
        tv[2]  = '{32'h0020A423, 32'h100, mk(0, 32'h10, 8, 0, 32'h1234, 2, 0, 7'h23, 0, 0)};
        tv[3]  = '{32'h123452B7, 32'h100, mk(5, 32'h12345000, 0, 0, 0, 5, 0, 7'h37, 0, 0)};
        tv[4]  = '{32'hFFFFF317, 32'h100, mk(6, 32'h100, 32'hFFFFF000, 0, 0, 7, 1, 7'h17, 0, 0)};
        tv[5]  = '{32'hFFDFF0EF, 32'h200, mk(1, 32'h200, 4, 32'hFFFFFFFC, 0, 7, 1, 7'h6f, 0, 0)};
        tv[6]  = '{32'hFF8082E7, 32'h300, mk(5, 32'h300, 4, 32'hFFFFFFF8, 0, 0, 1, 7'h67, 0, 0)};
        tv[7]  = '{32'h00208863, 32'h100, mk(0, 32'h10, 32'h1234, 16, 32'h1234, 0, 0, 7'h63, 0, 0)};
        tv[8]  = '{32'h0FF0000F, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h0f, 0, 0)};
        tv[9]  = '{32'h00000000, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h00, 1, 2)};
        tv[10] = '{32'h00000073, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h73, 1, 11)};
        tv[11] = '{32'h00100073, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h73, 1, 3)};
        tv[12] = '{32'h00200073, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h73, 1, 2)};
        tv[13] = '{32'h00000091, 32'h100, mk(0, 0, 0, 0, 0, 0, 0, 7'h11, 1, 2)};
        tv[14] = '{32'hFFC12203, 32'h100, mk(4, 32'h1234, 32'hFFFFFFFC, 0, 0, 2, 1, 7'h03, 0, 0)};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 149'(ov32), 149'(0));
        chk("rst_bundle", g32, '0);
        chk("rst_in_ready", 149'(ir32), 149'(1));
        rst_n = 1'b1;
        @(negedge clk);

        do_wb(5'd2, 32'h1234);
        do_wb(5'd1, 32'h10);

        // Vector table, one accepted instruction per entry
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            instruction = tv[i].ins;
            pc = tv[i].pc;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 149'(ov32), 149'(1));
            chk($sformatf("vec%0d_n32", i), g32, tv[i].exp);
            chk($sformatf("vec%0d_n16", i), g16, tv[i].exp);
        end

        // Write-back in the accept cycle is seen through the bypass
        instruction = 32'h002081B3; pc = 32'h100; in_valid = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hABCD;
        @(negedge clk);
        wb_en = 1'b0; in_valid = 1'b0;
        chk("bypass", g32, mk(3, 32'h10, 32'hABCD, 0, 0, 0, 0, 7'h33, 0, 0));

        // Stall: hold the bundle for 3 cycles with a new instruction waiting
        instruction = 32'h002081B3; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        instruction = 32'h123452B7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), 149'(ir32), 149'(0));
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 149'(ov32), 149'(1));
            chk($sformatf("stall%0d_hold", i), g32,
                mk(3, 32'h10, 32'hABCD, 0, 0, 0, 0, 7'h33, 0, 0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_next", g32, mk(5, 32'h12345000, 0, 0, 0, 5, 0, 7'h37, 0, 0));

        // Flush while holding kills both held and incoming instruction
        out_ready = 1'b0; flush = 1'b1; instruction = 32'hFFF00093;
        @(negedge clk);
        chk("flush_valid", 149'(ov32), 149'(0));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_drop", 149'(ov32), 149'(0));

        // add x17,x1,x2: legal with 32 regs, illegal with 16
        instruction = 32'h002088B3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("x17_n32", g32, mk(17, 32'h10, 32'hABCD, 0, 0, 0, 0, 7'h33, 0, 0));
        chk("x17_n16", g16, mk(0, 0, 0, 0, 0, 0, 0, 7'h33, 1, 2));

        // Asynchronous reset mid-stream
        instruction = 32'hFFF00093; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 149'(ov32), 149'(0));
        chk("arst_n32", g32, '0);
        chk("arst_n16", g16, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        instruction = 32'h002081B3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_read", g32, mk(3, 0, 0, 0, 0, 0, 0, 7'h33, 0, 0));
        @(negedge clk);

        // Randomized traffic against the reference model
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        exp_v = 1'b0;
        e32 = '0;
        e16 = '0;
        for (int i = 0; i < 2000; i++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            flush       = ($urandom % 16) == 0;
            wb_en       = $urandom % 2;
            wb_rd       = 5'($urandom);
            wb_data     = $urandom;
            instruction = rnd_insn();
            pc          = $urandom & 32'hFFFF_FFFC;
            #1;
            chk($sformatf("rnd%0d_in_ready", i), 149'(ir32), 149'(!exp_v || out_ready));
            chk($sformatf("rnd%0d_in_ready16", i), 149'(ir16), 149'(!exp_v || out_ready));
            acc = in_valid && (!exp_v || out_ready);
            if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
            if (acc && !flush) begin
                e32 = model(instruction, pc, mregs[instruction[19:15]],
                            mregs[instruction[24:20]], 32);
                e16 = model(instruction, pc, mregs[instruction[19:15]],
                            mregs[instruction[24:20]], 16);
            end
            exp_v = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : exp_v;
            @(negedge clk);
            chk($sformatf("rnd%0d_valid", i), 149'(ov32), 149'(exp_v));
            chk($sformatf("rnd%0d_valid16", i), 149'(ov16), 149'(exp_v));
            if (exp_v) begin
                chk($sformatf("rnd%0d_n32", i), g32, e32);
                chk($sformatf("rnd%0d_n16", i), g16, e16);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
